mgmt_spi_frame_engine: RTL and testbench
========================================

MGMT_SPI_FRAME_ENGINE -- requirements
Module: mgmt_spi_frame_engine

Interface
REQ-001 Parameter NUM_REGS, default 14: number of addressable configuration registers (0x00..NUM_REGS-1).
REQ-002 Parameter CMD_WRITE, default 8'h02: burst write command code.
REQ-003 Parameter CMD_READ, default 8'h03: burst read command code.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mgmt_clk_or_mgmt_cs_n  input  1  clock: rising edge with mgmt_cs_n=0 is one SPI bit; rising edge with mgmt_cs_n=1 is frame end.
REQ-006 mgmt_cs_n  input  1  chip-select level; selects bit edge vs frame-end edge.
REQ-007 mgmt_mosi  input  1  serial data, MSB first.
REQ-008 miso_bit  output  1  MSB of TX shift register; an external falling-edge stage drives MISO from it.
REQ-009 reg_rd_addr  output  8  combinational address whose reg_rd_data is captured at the next edge.
REQ-010 reg_rd_data  input  8  combinational register-file read data for reg_rd_addr.
REQ-011 reg_wr_en  output  1  one-cycle write strobe.
REQ-012 reg_wr_addr / reg_wr_data  output  8 / 8  write target and data, valid while reg_wr_en=1.
REQ-013 frame_active  output  1  high from first bit edge to frame-end edge.
REQ-014 frame_err / cmd_err  output  1 / 1  sticky error flags (REQ-024, REQ-025).

Function
REQ-015 Bit edge: shift mosi into rx_shift; bit_cnt (3 bits) increments and wraps 7->0; byte completes when bit_cnt=7.
REQ-016 States: IDLE, ADDR, WDATA, RDATA, IGNORE; each transition occurs only on a byte-completing edge.
REQ-017 IDLE byte done: byte=CMD_WRITE->ADDR, write mode; byte=CMD_READ->ADDR, read mode; otherwise->IGNORE, set cmd_err.
REQ-018 ADDR byte done: addr_ptr <= byte; write->WDATA; read->RDATA, tx_shift <= reg_rd_data with reg_rd_addr=byte.
REQ-019 WDATA byte done: reg_wr_en=1 for exactly that edge's cycle, reg_wr_addr=addr_ptr, reg_wr_data=byte; only when addr_ptr<NUM_REGS, else no strobe; then advance addr_ptr.
REQ-020 RDATA: non-final bit edges shift tx_shift left, filling 0; byte done: advance addr_ptr, tx_shift <= reg_rd_data for the advanced address.
REQ-021 Advance rule: addr_ptr=NUM_REGS-1 -> 0, otherwise +1; in ADDR, an address >=NUM_REGS is kept and reads 8'hFF (tx load forced to FF).
REQ-022 reg_rd_addr = next addr_ptr value at byte-completing edges in ADDR/RDATA, else addr_ptr.
REQ-023 miso_bit = tx_shift[7] in RDATA, else 0.
REQ-024 Frame-end edge: state->IDLE, bit_cnt->0, frame_active->0, reg_wr_en->0; if bit_cnt!=0, set frame_err; addr_ptr and tx_shift are retained.
REQ-025 frame_err and cmd_err clear on the first bit edge of the next frame.
REQ-026 IGNORE: bits are shifted but produce no write and no TX load until frame end.
REQ-027 reg_wr_en is deasserted on every edge other than the strobing edge of REQ-019.

Reset
REQ-028 rst forces: state=IDLE, bit_cnt=0, rx_shift=0, tx_shift=0, addr_ptr=0, all outputs 0, reg_rd_addr=0.
REQ-029 rst asserted mid-frame aborts the frame with no write strobe; the next frame starts in IDLE.

Structure
REQ-030 Package mgmt_spi_pkg: state encoding, CMD_WRITE/CMD_READ defaults, NUM_REGS default, 8'hFF out-of-range read value.
REQ-031 One sub-module, mgmt_spi_shifter: rx shift register plus bit_cnt with a byte_done output; the FSM stays in the parent.

Verification
REQ-032 Frame 02,0C,A5 -> one reg_wr_en pulse, addr 0x0C, data 0xA5; frame_err=0.
REQ-033 Frame 02,0C,11,22,33 -> writes (0C,11),(0D,22),(00,33); the wrap follows REQ-021.
REQ-034 Frame 03,0D plus 16 bits, regfile 0D=5A, 00=C3 -> miso_bit sequence 5A then C3 MSB-first.
REQ-035 Frame 03,20 plus 8 bits -> miso_bit sequence FF; no write strobe.
REQ-036 Frame 7E,0C,A5 -> cmd_err=1, no write; next frame 02,00,01 clears cmd_err and writes (00,01).
REQ-037 Frame 02,0C with 5 bits then CS high -> frame_err=1, no write; rst asserted mid-byte -> all outputs 0 immediately.

Source files
------------

// File: rtl/mgmt_spi_pkg.sv
// Shared definitions for the management SPI frame engine: frame-state
// encoding, default command codes, register count, and the address helpers
// used by the frame FSM.
package mgmt_spi_pkg;

    // Frame parser states. Each state covers one byte slot of the frame.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,   // waiting for the command byte
        ST_ADDR   = 3'd1,   // waiting for the start address byte
        ST_WDATA  = 3'd2,   // burst write data bytes
        ST_RDATA  = 3'd3,   // burst read, shifting register data out
        ST_IGNORE = 3'd4    // unknown command, discard until frame end
    } state_t;

    localparam int         DEF_NUM_REGS   = 14;
    localparam logic [7:0] DEF_CMD_WRITE  = 8'h02;
    localparam logic [7:0] DEF_CMD_READ   = 8'h03;

    // Value shifted out for any address outside the register file.
    localparam logic [7:0] OOR_READ_VALUE = 8'hFF;

    // True when addr selects an implemented register.
    function automatic logic addr_in_range(input logic [7:0] addr, input int num_regs);
        return int'(addr) < num_regs;
    endfunction

    // Burst address step: the last implemented register wraps to 0, any other
    // address (including out-of-range ones) simply increments.
    function automatic logic [7:0] addr_advance(input logic [7:0] addr, input int num_regs);
        if (int'(addr) == num_regs - 1) begin
            return 8'h00;
        end
        return addr + 8'h01;
    endfunction

    // Byte to load into the TX shifter for a given address.
    function automatic logic [7:0] tx_load_value(input logic [7:0] addr,
                                                 input logic [7:0] rd_data,
                                                 input int         num_regs);
        return addr_in_range(addr, num_regs) ? rd_data : OOR_READ_VALUE;
    endfunction

endpackage

// File: rtl/mgmt_spi_frame_engine_if.sv
// Register-file bus between the frame engine (master) and the configuration
// register file (slave). Reads are combinational; writes are a one-cycle
// strobe with address and data held alongside it.
interface mgmt_spi_frame_engine_if;

    logic [7:0] reg_rd_addr;
    logic [7:0] reg_rd_data;
    logic       reg_wr_en;
    logic [7:0] reg_wr_addr;
    logic [7:0] reg_wr_data;

    modport master (
        output reg_rd_addr,
        input  reg_rd_data,
        output reg_wr_en,
        output reg_wr_addr,
        output reg_wr_data
    );

    modport slave (
        input  reg_rd_addr,
        output reg_rd_data,
        input  reg_wr_en,
        input  reg_wr_addr,
        input  reg_wr_data
    );

endinterface

// File: rtl/mgmt_spi_shifter.sv
// Receive side of the management SPI: collects MOSI bits MSB first and
// counts bits within the current byte. The byte being completed is presented
// combinationally so the FSM can act on it at the completing edge itself.
module mgmt_spi_shifter (
    input  logic       rst,
    input  logic       mgmt_clk_or_mgmt_cs_n,
    input  logic       mgmt_cs_n,
    input  logic       mgmt_mosi,
    output logic       byte_done,
    output logic       mid_byte,
    output logic [7:0] rx_byte
);

    // Only the seven most recent bits need storing: the eighth bit of a byte
    // is on mgmt_mosi during the edge that completes it.
    logic [6:0] rx_shift_reg;
    logic [6:0] rx_shift_next;
    logic [2:0] bit_cnt_reg;
    logic [2:0] bit_cnt_next;

    // rx_byte is the shift register contents as they would be after this edge.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rx_byte
            if (gi == 0) begin : g_lsb
                assign rx_byte[gi] = mgmt_mosi;
            end else begin : g_hist
                assign rx_byte[gi] = rx_shift_reg[gi-1];
            end
        end
    endgenerate

    // Bit edges shift and count; a frame-end edge only re-aligns the counter.
    assign rx_shift_next = mgmt_cs_n ? rx_shift_reg : rx_byte[6:0];
    assign bit_cnt_next  = mgmt_cs_n ? 3'd0 : bit_cnt_reg + 3'd1;

    assign byte_done = !mgmt_cs_n && (bit_cnt_reg == 3'd7);
    assign mid_byte  = (bit_cnt_reg != 3'd0);

    // Shift/count state register.
    always_ff @(posedge mgmt_clk_or_mgmt_cs_n or posedge rst) begin
        if (rst) begin
            rx_shift_reg <= '0;
            bit_cnt_reg  <= '0;
        end else begin
            rx_shift_reg <= rx_shift_next;
            bit_cnt_reg  <= bit_cnt_next;
        end
    end

endmodule

// File: rtl/mgmt_spi_frame_engine.sv
// Management SPI frame engine. Frames are: command byte, start address byte,
// then any number of data bytes. Write bursts strobe the register file once
// per data byte; read bursts preload the TX shifter with register data at
// each byte boundary so the next byte is ready before its first bit goes out.
// The clock is the SPI clock ORed with chip select: edges with CS low are bit
// edges, the edge produced by CS rising ends the frame.
module mgmt_spi_frame_engine
    import mgmt_spi_pkg::*;
#(
    parameter int         NUM_REGS  = DEF_NUM_REGS,
    parameter logic [7:0] CMD_WRITE = DEF_CMD_WRITE,
    parameter logic [7:0] CMD_READ  = DEF_CMD_READ
) (
    input  logic                            rst,
    input  logic                            mgmt_clk_or_mgmt_cs_n,
    input  logic                            mgmt_cs_n,
    input  logic                            mgmt_mosi,
    output logic                            miso_bit,
    mgmt_spi_frame_engine_if.master         reg_bus,
    output logic                            frame_active,
    output logic                            frame_err,
    output logic                            cmd_err
);

    state_t     state_reg,        state_next;
    logic       write_mode_reg,   write_mode_next;
    logic [7:0] addr_ptr_reg,     addr_ptr_next;
    logic [7:0] tx_shift_reg,     tx_shift_next;
    logic       frame_active_reg, frame_active_next;
    logic       frame_err_reg,    frame_err_next;
    logic       cmd_err_reg,      cmd_err_next;
    logic       wr_en_reg,        wr_en_next;
    logic [7:0] wr_addr_reg,      wr_addr_next;
    logic [7:0] wr_data_reg,      wr_data_next;

    logic       byte_done;
    logic       mid_byte;
    logic [7:0] rx_byte;
    logic [7:0] addr_ptr_adv;
    logic [7:0] rd_addr_comb;

    mgmt_spi_shifter u_shifter (
        .rst                   (rst),
        .mgmt_clk_or_mgmt_cs_n (mgmt_clk_or_mgmt_cs_n),
        .mgmt_cs_n             (mgmt_cs_n),
        .mgmt_mosi             (mgmt_mosi),
        .byte_done             (byte_done),
        .mid_byte              (mid_byte),
        .rx_byte               (rx_byte)
    );

    assign addr_ptr_adv = addr_advance(addr_ptr_reg, NUM_REGS);

    // Read address: at a byte-completing edge that loads the TX shifter, point
    // at the address the pointer is about to take so its data is captured on
    // that same edge; otherwise follow the pointer.
    always_comb begin
        rd_addr_comb = addr_ptr_reg;
        if (byte_done) begin
            if (state_reg == ST_ADDR) begin
                rd_addr_comb = rx_byte;
            end else if (state_reg == ST_RDATA) begin
                rd_addr_comb = addr_ptr_adv;
            end
        end
    end

    // Next-state and datapath updates for one edge.
    always_comb begin
        state_next        = state_reg;
        write_mode_next   = write_mode_reg;
        addr_ptr_next     = addr_ptr_reg;
        tx_shift_next     = tx_shift_reg;
        frame_active_next = frame_active_reg;
        frame_err_next    = frame_err_reg;
        cmd_err_next      = cmd_err_reg;
        wr_en_next        = 1'b0;
        wr_addr_next      = wr_addr_reg;
        wr_data_next      = wr_data_reg;

        if (mgmt_cs_n) begin
            // Frame end: pointer and TX data survive; a partial byte is an error.
            state_next        = ST_IDLE;
            frame_active_next = 1'b0;
            if (mid_byte) begin
                frame_err_next = 1'b1;
            end
        end else begin
            frame_active_next = 1'b1;
            // The first bit of a frame clears the previous frame's errors.
            if (!frame_active_reg) begin
                frame_err_next = 1'b0;
                cmd_err_next   = 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    if (byte_done) begin
                        if (rx_byte == CMD_WRITE) begin
                            state_next      = ST_ADDR;
                            write_mode_next = 1'b1;
                        end else if (rx_byte == CMD_READ) begin
                            state_next      = ST_ADDR;
                            write_mode_next = 1'b0;
                        end else begin
                            state_next   = ST_IGNORE;
                            cmd_err_next = 1'b1;
                        end
                    end
                end

                ST_ADDR: begin
                    if (byte_done) begin
                        // Out-of-range start addresses are kept as-is.
                        addr_ptr_next = rx_byte;
                        if (write_mode_reg) begin
                            state_next = ST_WDATA;
                        end else begin
                            state_next    = ST_RDATA;
                            tx_shift_next = tx_load_value(rx_byte, reg_bus.reg_rd_data, NUM_REGS);
                        end
                    end
                end

                ST_WDATA: begin
                    if (byte_done) begin
                        if (addr_in_range(addr_ptr_reg, NUM_REGS)) begin
                            wr_en_next   = 1'b1;
                            wr_addr_next = addr_ptr_reg;
                            wr_data_next = rx_byte;
                        end
                        addr_ptr_next = addr_ptr_adv;
                    end
                end

                ST_RDATA: begin
                    if (byte_done) begin
                        addr_ptr_next = addr_ptr_adv;
                        tx_shift_next = tx_load_value(addr_ptr_adv, reg_bus.reg_rd_data, NUM_REGS);
                    end else begin
                        tx_shift_next = {tx_shift_reg[6:0], 1'b0};
                    end
                end

                ST_IGNORE: begin
                    // Bits are consumed by the shifter; nothing else happens.
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Frame state register.
    always_ff @(posedge mgmt_clk_or_mgmt_cs_n or posedge rst) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            write_mode_reg   <= 1'b0;
            addr_ptr_reg     <= '0;
            tx_shift_reg     <= '0;
            frame_active_reg <= 1'b0;
            frame_err_reg    <= 1'b0;
            cmd_err_reg      <= 1'b0;
            wr_en_reg        <= 1'b0;
            wr_addr_reg      <= '0;
            wr_data_reg      <= '0;
        end else begin
            state_reg        <= state_next;
            write_mode_reg   <= write_mode_next;
            addr_ptr_reg     <= addr_ptr_next;
            tx_shift_reg     <= tx_shift_next;
            frame_active_reg <= frame_active_next;
            frame_err_reg    <= frame_err_next;
            cmd_err_reg      <= cmd_err_next;
            wr_en_reg        <= wr_en_next;
            wr_addr_reg      <= wr_addr_next;
            wr_data_reg      <= wr_data_next;
        end
    end

    // The external falling-edge stage only sees shifter data during reads.
    assign miso_bit            = (state_reg == ST_RDATA) ? tx_shift_reg[7] : 1'b0;
    assign reg_bus.reg_rd_addr = rd_addr_comb;
    assign reg_bus.reg_wr_en   = wr_en_reg;
    assign reg_bus.reg_wr_addr = wr_addr_reg;
    assign reg_bus.reg_wr_data = wr_data_reg;
    assign frame_active        = frame_active_reg;
    assign frame_err           = frame_err_reg;
    assign cmd_err             = cmd_err_reg;

endmodule

// File: tb/tb_mgmt_spi_frame_engine.sv
// Bench for mgmt_spi_frame_engine: directed frames followed by random frames,
// each compared bit-by-bit against a frame-level reference model.
module tb_mgmt_spi_frame_engine;

    localparam int         NUM_REGS = 14;
    localparam logic [7:0] CMD_W    = 8'h02;
    localparam logic [7:0] CMD_R    = 8'h03;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic cs_n  = 1'b1;
    logic mosi  = 1'b0;
    logic miso_bit;
    logic frame_active;
    logic frame_err;
    logic cmd_err;

    mgmt_spi_frame_engine_if bus ();

    logic [7:0] regs [0:255];
    assign bus.reg_rd_data = regs[bus.reg_rd_addr];

    mgmt_spi_frame_engine #(
        .NUM_REGS  (NUM_REGS),
        .CMD_WRITE (CMD_W),
        .CMD_READ  (CMD_R)
    ) dut (
        .rst                   (rst),
        .mgmt_clk_or_mgmt_cs_n (clk),
        .mgmt_cs_n             (cs_n),
        .mgmt_mosi             (mosi),
        .miso_bit              (miso_bit),
        .reg_bus               (bus),
        .frame_active          (frame_active),
        .frame_err             (frame_err),
        .cmd_err               (cmd_err)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] fbytes [$];
    int         fbits;
    logic       exp_miso [$];
    logic [7:0] exp_wa [$];
    logic [7:0] exp_wd [$];
    logic [7:0] obs_wa [$];
    logic [7:0] obs_wd [$];
    logic       exp_cmd_err;
    logic       exp_frame_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Burst address step: last register wraps to 0, everything else counts up.
    function automatic logic [7:0] next_addr(input logic [7:0] a);
        if (int'(a) == NUM_REGS - 1) return 8'h00;
        return a + 8'h01;
    endfunction

    // Frame-level model: works out the writes, the MISO bit stream and the
    // error flags from the byte list and total bit count.
    task automatic build_model();
        int         full;
        logic [7:0] a;
        logic [7:0] val;
        logic       is_wr;
        logic       is_rd;
        full          = fbits / 8;
        exp_frame_err = (fbits % 8) != 0;
        exp_cmd_err   = 1'b0;
        is_wr         = 1'b0;
        is_rd         = 1'b0;
        exp_miso.delete();
        exp_wa.delete();
        exp_wd.delete();
        for (int k = 0; k < fbits; k++) exp_miso.push_back(1'b0);
        if (full >= 1) begin
            if (fbytes[0] == CMD_W)      is_wr = 1'b1;
            else if (fbytes[0] == CMD_R) is_rd = 1'b1;
            else                         exp_cmd_err = 1'b1;
        end
        if (full >= 2 && is_wr) begin
            a = fbytes[1];
            for (int j = 2; j < full; j++) begin
                if (int'(a) < NUM_REGS) begin
                    exp_wa.push_back(a);
                    exp_wd.push_back(fbytes[j]);
                end
                a = next_addr(a);
            end
        end
        if (full >= 2 && is_rd) begin
            for (int k = 16; k < fbits; k++) begin
                a = fbytes[1];
                for (int s = 0; s < (k - 16) / 8; s++) a = next_addr(a);
                val = (int'(a) < NUM_REGS) ? regs[a] : 8'hFF;
                exp_miso[k] = val[7 - (k % 8)];
            end
        end
    endtask

    // Clock out the bits of one frame, without raising chip select.
    task automatic send_bits(input string name, input int nbits, input bit check_miso);
        logic [7:0] cur;
        for (int k = 0; k < nbits; k++) begin
            @(negedge clk);
            cs_n = 1'b0;
            cur  = fbytes[k / 8];
            mosi = cur[7 - (k % 8)];
            #1;
            if (check_miso) check({name, "/miso"}, {31'd0, miso_bit}, {31'd0, exp_miso[k]});
            @(posedge clk);
            #1;
            if (k == 0) begin
                check({name, "/active_first"}, {31'd0, frame_active}, 32'd1);
                check({name, "/ferr_clear"}, {31'd0, frame_err}, 32'd0);
                check({name, "/cerr_clear"}, {31'd0, cmd_err}, 32'd0);
            end
            if (bus.reg_wr_en === 1'b1) begin
                obs_wa.push_back(bus.reg_wr_addr);
                obs_wd.push_back(bus.reg_wr_data);
            end
        end
    endtask

    // Full transaction: model, bits, frame end, then the end-of-frame checks.
    task automatic run_frame(input string name);
        int n;
        build_model();
        obs_wa.delete();
        obs_wd.delete();
        send_bits(name, fbits, 1'b1);
        @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        @(posedge clk);
        #1;
        check({name, "/wr_en_end"}, {31'd0, bus.reg_wr_en}, 32'd0);
        check({name, "/active_end"}, {31'd0, frame_active}, 32'd0);
        check({name, "/frame_err"}, {31'd0, frame_err}, {31'd0, exp_frame_err});
        check({name, "/cmd_err"}, {31'd0, cmd_err}, {31'd0, exp_cmd_err});
        check({name, "/wr_count"}, obs_wa.size(), exp_wa.size());
        n = (obs_wa.size() < exp_wa.size()) ? obs_wa.size() : exp_wa.size();
        for (int i = 0; i < n; i++) begin
            check({name, "/wr_addr"}, {24'd0, obs_wa[i]}, {24'd0, exp_wa[i]});
            check({name, "/wr_data"}, {24'd0, obs_wd[i]}, {24'd0, exp_wd[i]});
        end
        for (int i = 0; i < exp_wa.size(); i++) regs[exp_wa[i]] = exp_wd[i];
        $display("[TB] frame %s: %0d bits, %0d writes, cmd_err=%0b frame_err=%0b",
                 name, fbits, obs_wa.size(), cmd_err, frame_err);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "/miso"}, {31'd0, miso_bit}, 32'd0);
        check({name, "/rd_addr"}, {24'd0, bus.reg_rd_addr}, 32'd0);
        check({name, "/wr_en"}, {31'd0, bus.reg_wr_en}, 32'd0);
        check({name, "/wr_addr"}, {24'd0, bus.reg_wr_addr}, 32'd0);
        check({name, "/wr_data"}, {24'd0, bus.reg_wr_data}, 32'd0);
        check({name, "/active"}, {31'd0, frame_active}, 32'd0);
        check({name, "/frame_err"}, {31'd0, frame_err}, 32'd0);
        check({name, "/cmd_err"}, {31'd0, cmd_err}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nd;
        int kind;
        logic [7:0] a;
        for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);

        // Reset state.
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        $display("[TB] reset: outputs checked");
        @(negedge clk);
        rst = 1'b0;

        // Single write.
        fbytes = '{8'h02, 8'h0C, 8'hA5};
        fbits  = 24;
        run_frame("wr_single");
        if (obs_wa.size() == 1) begin
            check("wr_single/addr0c", {24'd0, obs_wa[0]}, 32'h0C);
            check("wr_single/dataa5", {24'd0, obs_wd[0]}, 32'hA5);
        end

        // Burst write across the register wrap.
        fbytes = '{8'h02, 8'h0C, 8'h11, 8'h22, 8'h33};
        fbits  = 40;
        run_frame("wr_wrap");
        if (obs_wa.size() == 3) check("wr_wrap/addr00", {24'd0, obs_wa[2]}, 32'h00);

        // Burst read across the wrap.
        regs[8'h0D] = 8'h5A;
        regs[8'h00] = 8'hC3;
        fbytes = '{8'h03, 8'h0D, 8'h00, 8'h00};
        fbits  = 32;
        run_frame("rd_wrap");

        // Read from an out-of-range address.
        fbytes = '{8'h03, 8'h20, 8'h00};
        fbits  = 24;
        run_frame("rd_oor");

        // Unknown command then a valid write.
        fbytes = '{8'h7E, 8'h0C, 8'hA5};
        fbits  = 24;
        run_frame("bad_cmd");
        fbytes = '{8'h02, 8'h00, 8'h01};
        fbits  = 24;
        run_frame("after_bad");

        // Frame ends mid-byte.
        fbytes = '{8'h02, 8'h0C, 8'hF0};
        fbits  = 21;
        run_frame("short");

        // Reset in the middle of a data byte.
        fbytes = '{8'h02, 8'h0C, 8'hF0};
        fbits  = 19;
        obs_wa.delete();
        obs_wd.delete();
        build_model();
        send_bits("mid_rst", 19, 1'b0);
        check("mid_rst/active_before", {31'd0, frame_active}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        check("mid_rst/no_write", obs_wa.size(), 32'd0);
        $display("[TB] mid_rst: reset during data byte");
        @(negedge clk);
        rst  = 1'b0;
        cs_n = 1'b1;
        @(posedge clk);
        fbytes = '{8'h02, 8'h05, 8'h77};
        fbits  = 24;
        run_frame("after_rst");

        // Random frames.
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            fbytes.delete();
            if (kind < 4)      fbytes.push_back(CMD_W);
            else if (kind < 8) fbytes.push_back(CMD_R);
            else               fbytes.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) a = 8'($urandom);
            else                           a = 8'($urandom_range(0, NUM_REGS - 1));
            fbytes.push_back(a);
            nd = $urandom_range(0, 4);
            for (int j = 0; j < nd + 1; j++) fbytes.push_back(8'($urandom));
            fbits = (2 + nd) * 8;
            if ($urandom_range(0, 3) == 0) fbits = fbits + $urandom_range(1, 7);
            if ($urandom_range(0, 7) == 0) fbits = $urandom_range(1, 15);
            run_frame($sformatf("rand%0d", f));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
